// File: rtl/jtbubl_snd_comm_if.sv
// Main/sound command channel bus bundle.
// The slave side is the comm block; the master side drives both CPUs' strobes.
interface jtbubl_snd_comm_if;
  logic       main_wr;
  logic [7:0] main_dout;
  logic       main_rd;
  logic [7:0] main_reply;
  logic       reply_full;
  logic       snd_cs;
  logic [1:0] snd_addr;
  logic       snd_rdn;
  logic       snd_wrn;
  logic [7:0] snd_dout;
  logic [7:0] snd_din;
  logic       snd_nmi_n;

  modport slave (
    input  main_wr, main_dout, main_rd,
    input  snd_cs, snd_addr, snd_rdn,
    input  snd_wrn, snd_dout,
    output main_reply, reply_full,
    output snd_din, snd_nmi_n
  );

  modport master (
    output main_wr, main_dout, main_rd,
    output snd_cs, snd_addr, snd_rdn,
    output snd_wrn, snd_dout,
    input  main_reply, reply_full,
    input  snd_din, snd_nmi_n
  );
endinterface

// File: rtl/jtbubl_snd_comm.sv
// Sound-CPU end of the main-to-sound command channel.
// Latches commands, returns replies and shapes a gated NMI pulse.
module jtbubl_snd_comm #(
  parameter int NMI_W      = 4,
  parameter bit NMI_EN_RST = 1'b1
) (
  input  logic rst,
  input  logic clk24,
  input  logic cen3,
  jtbubl_snd_comm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } st_t;

  logic       wr_l_q, wr_l_d;
  logic       rd_l_q, rd_l_d;
  logic       srd_l_q, srd_l_d;
  logic       swr_l_q, swr_l_d;
  logic [7:0] latch_q, latch_d;
  logic       cmd_full_q, cmd_full_d;
  logic       overrun_q, overrun_d;
  logic [7:0] reply_q, reply_d;
  logic       reply_full_q, reply_full_d;
  logic       nmi_en_q, nmi_en_d;
  logic       pend_q, pend_d;
  st_t        state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       nmi_n_q, nmi_n_d;

  logic srd, swr;
  logic main_we, main_re, srd_e, swr_e;
  logic cmd_clr, ovr_clr, trig, consume;

  assign srd     = bus.snd_cs & ~bus.snd_rdn;
  assign swr     = bus.snd_cs & ~bus.snd_wrn;
  assign main_we = bus.main_wr & ~wr_l_q;
  assign main_re = bus.main_rd & ~rd_l_q;
  assign srd_e   = srd & ~srd_l_q;
  assign swr_e   = swr & ~swr_l_q;

  assign bus.main_reply = reply_q;
  assign bus.reply_full = reply_full_q;
  assign bus.snd_nmi_n  = nmi_n_q;

  // Sound-side read mux, open bus when not selected
  always_comb begin
    bus.snd_din = 8'hFF;
    if (bus.snd_cs) begin
      unique case (bus.snd_addr)
        2'd0:    bus.snd_din = latch_q;
        2'd1:    bus.snd_din = {5'b0, nmi_en_q,
                                overrun_q, cmd_full_q};
        default: bus.snd_din = 8'hFF;
      endcase
    end
  end

  // Next-state for flags, latch, reply and NMI shaper
  always_comb begin
    wr_l_d       = bus.main_wr;
    rd_l_d       = bus.main_rd;
    srd_l_d      = srd;
    swr_l_d      = swr;
    latch_d      = latch_q;
    cmd_full_d   = cmd_full_q;
    overrun_d    = overrun_q;
    reply_d      = reply_q;
    reply_full_d = reply_full_q;
    nmi_en_d     = nmi_en_q;
    pend_d       = pend_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    nmi_n_d      = nmi_n_q;
    consume      = 1'b0;

    cmd_clr = (srd_e & (bus.snd_addr == 2'd0))
            | (swr_e & (bus.snd_addr == 2'd2));
    ovr_clr = (srd_e & (bus.snd_addr == 2'd1))
            | (swr_e & (bus.snd_addr == 2'd2));

    if (main_we) begin
      latch_d    = bus.main_dout;
      cmd_full_d = 1'b1;
    end else if (cmd_clr) begin
      cmd_full_d = 1'b0;
    end

    if (main_we & cmd_full_q & ~cmd_clr)
      overrun_d = 1'b1;
    else if (ovr_clr)
      overrun_d = 1'b0;

    if (swr_e & (bus.snd_addr == 2'd0)) begin
      reply_d      = bus.snd_dout;
      reply_full_d = 1'b1;
    end else if (main_re) begin
      reply_full_d = 1'b0;
    end

    if (swr_e & (bus.snd_addr == 2'd1))
      nmi_en_d = bus.snd_dout[0];

    trig = (main_we & nmi_en_q)
         | (nmi_en_d & ~nmi_en_q & cmd_full_q);

    if (cen3) begin
      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_d = PULSE;
            nmi_n_d = 1'b0;
            cnt_d   = 4'(NMI_W - 1);
            consume = 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q == 4'd0) begin
            state_d = GAP;
            nmi_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        GAP: state_d = IDLE;
        default: begin
          state_d = IDLE;
          nmi_n_d = 1'b1;
        end
      endcase
    end

    if (consume)
      pend_d = 1'b0;
    if (trig)
      pend_d = 1'b1;
    if (nmi_en_q & ~nmi_en_d)
      pend_d = 1'b0;
  end

  // State registers
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      wr_l_q       <= 1'b0;
      rd_l_q       <= 1'b0;
      srd_l_q      <= 1'b0;
      swr_l_q      <= 1'b0;
      latch_q      <= 8'd0;
      cmd_full_q   <= 1'b0;
      overrun_q    <= 1'b0;
      reply_q      <= 8'd0;
      reply_full_q <= 1'b0;
      nmi_en_q     <= NMI_EN_RST;
      pend_q       <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      nmi_n_q      <= 1'b1;
    end else begin
      wr_l_q       <= wr_l_d;
      rd_l_q       <= rd_l_d;
      srd_l_q      <= srd_l_d;
      swr_l_q      <= swr_l_d;
      latch_q      <= latch_d;
      cmd_full_q   <= cmd_full_d;
      overrun_q    <= overrun_d;
      reply_q      <= reply_d;
      reply_full_q <= reply_full_d;
      nmi_en_q     <= nmi_en_d;
      pend_q       <= pend_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nmi_n_q      <= nmi_n_d;
    end
  end

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Bench for the main/sound command channel.
// Read data and NMI pulse widths are checked through scoreboards.
module tb_jtbubl_snd_comm;
  localparam int NMI_W = 4;
  localparam int PW    = NMI_W * 8;

  logic rst;
  logic clk24;
  logic cen3;
  logic [2:0] cen_cnt;
  int n_tests;
  int n_fail;

  jtbubl_snd_comm_if bus();

  jtbubl_snd_comm #(
    .NMI_W(NMI_W),
    .NMI_EN_RST(1'b1)
  ) dut (
    .rst(rst),
    .clk24(clk24),
    .cen3(cen3),
    .bus(bus)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  initial begin
    cen_cnt = 3'd0;
    cen3    = 1'b0;
  end

  always @(negedge clk24) begin
    cen_cnt <= cen_cnt + 3'd1;
    cen3    <= (cen_cnt == 3'd7);
  end

  logic   mon_clr;
  int     low_cnt;
  int     obs_w[$];
  logic [7:0] exp_rd[$];
  int     exp_w[$];

  initial low_cnt = 0;

  always @(negedge clk24) begin
    if (mon_clr) begin
      obs_w.delete();
      low_cnt <= 0;
    end else if (!bus.snd_nmi_n) begin
      low_cnt <= low_cnt + 1;
    end else if (low_cnt != 0) begin
      obs_w.push_back(low_cnt);
      low_cnt <= 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk24);
    #1;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
    exp_w.delete();
  endtask

  task automatic main_write(input logic [7:0] d);
    bus.main_dout = d;
    bus.main_wr   = 1'b1;
    tick(3);
    bus.main_wr   = 1'b0;
    tick(2);
  endtask

  task automatic snd_rd(input string tag,
                        input logic [1:0] a,
                        input logic [7:0] e);
    logic [7:0] got;
    exp_rd.push_back(e);
    bus.snd_cs   = 1'b1;
    bus.snd_addr = a;
    bus.snd_rdn  = 1'b0;
    #1;
    got = bus.snd_din;
    tick(2);
    bus.snd_cs  = 1'b0;
    bus.snd_rdn = 1'b1;
    tick(2);
    chk(tag, {24'd0, got}, {24'd0, exp_rd.pop_front()});
  endtask

  task automatic snd_wr(input logic [1:0] a,
                        input logic [7:0] d);
    bus.snd_cs   = 1'b1;
    bus.snd_addr = a;
    bus.snd_dout = d;
    bus.snd_wrn  = 1'b0;
    tick(2);
    bus.snd_cs  = 1'b0;
    bus.snd_wrn = 1'b1;
    tick(2);
  endtask

  task automatic wait_low(input string tag);
    int k;
    k = 0;
    while (bus.snd_nmi_n && k < 200) begin
      tick(1);
      k++;
    end
    chk(tag, {31'd0, bus.snd_nmi_n}, 32'd0);
  endtask

  task automatic chk_pulses(input string tag);
    int k;
    k = 0;
    while (obs_w.size() < exp_w.size() && k < 400) begin
      tick(1);
      k++;
    end
    tick(200);
    chk({tag, "_cnt"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      if (i < obs_w.size())
        chk({tag, "_w"}, obs_w[i], exp_w[i]);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    mon_clr       = 1'b0;
    bus.main_wr   = 1'b0;
    bus.main_dout = 8'd0;
    bus.main_rd   = 1'b0;
    bus.snd_cs    = 1'b0;
    bus.snd_addr  = 2'd0;
    bus.snd_rdn   = 1'b1;
    bus.snd_wrn   = 1'b1;
    bus.snd_dout  = 8'd0;
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    mon_reset();

    chk("rst_nmi", {31'd0, bus.snd_nmi_n}, 32'd1);
    chk("rst_rfull", {31'd0, bus.reply_full}, 32'd0);
    chk("rst_reply", {24'd0, bus.main_reply}, 32'd0);
    chk("nocs_din", {24'd0, bus.snd_din}, 32'hFF);
    snd_rd("rst_stat", 2'd1, 8'h04);

    exp_w.push_back(PW);
    main_write(8'h5A);
    chk_pulses("p1");
    snd_rd("p1_stat", 2'd1, 8'h05);
    snd_rd("p1_latch", 2'd0, 8'h5A);
    snd_rd("p1_stat2", 2'd1, 8'h04);

    mon_reset();
    exp_w.push_back(PW);
    exp_w.push_back(PW);
    main_write(8'h11);
    wait_low("ovr_low");
    main_write(8'h22);
    chk_pulses("ovr");
    snd_rd("ovr_stat", 2'd1, 8'h07);
    snd_rd("ovr_latch", 2'd0, 8'h22);
    snd_rd("ovr_stat2", 2'd1, 8'h04);

    mon_reset();
    snd_wr(2'd1, 8'h00);
    main_write(8'h33);
    chk_pulses("dis");
    exp_w.push_back(PW);
    snd_wr(2'd1, 8'h01);
    chk_pulses("ena");
    snd_rd("ena_latch", 2'd0, 8'h33);

    snd_wr(2'd0, 8'hC7);
    chk("rep_full", {31'd0, bus.reply_full}, 32'd1);
    chk("rep_val", {24'd0, bus.main_reply}, 32'hC7);
    bus.main_rd = 1'b1;
    tick(10);
    chk("rep_clr", {31'd0, bus.reply_full}, 32'd0);
    chk("rep_hold", {24'd0, bus.main_reply}, 32'hC7);
    snd_wr(2'd0, 8'h3C);
    tick(4);
    chk("rep_lvl", {31'd0, bus.reply_full}, 32'd1);
    bus.main_rd = 1'b0;
    tick(2);
    chk("rep_val2", {24'd0, bus.main_reply}, 32'h3C);
    bus.main_rd = 1'b1;
    tick(2);
    bus.main_rd = 1'b0;
    tick(2);
    chk("rep_clr2", {31'd0, bus.reply_full}, 32'd0);

    main_write(8'h44);
    bus.main_dout = 8'h9E;
    bus.main_wr   = 1'b1;
    bus.snd_cs    = 1'b1;
    bus.snd_addr  = 2'd0;
    bus.snd_rdn   = 1'b0;
    tick(3);
    bus.main_wr = 1'b0;
    bus.snd_cs  = 1'b0;
    bus.snd_rdn = 1'b1;
    tick(2);
    snd_rd("sim_stat", 2'd1, 8'h05);
    snd_rd("sim_latch", 2'd0, 8'h9E);

    main_write(8'h55);
    main_write(8'h66);
    snd_wr(2'd2, 8'h00);
    snd_rd("fl_stat", 2'd1, 8'h04);
    snd_rd("rd2", 2'd2, 8'hFF);
    snd_rd("rd3", 2'd3, 8'hFF);
    snd_wr(2'd3, 8'hAA);
    snd_rd("wr3_stat", 2'd1, 8'h04);
    snd_rd("fl_latch", 2'd0, 8'h66);

    tick(300);
    mon_reset();
    main_write(8'h77);
    wait_low("rst_low");
    rst = 1'b1;
    #2;
    chk("rst_async", {31'd0, bus.snd_nmi_n}, 32'd1);
    tick(3);
    rst = 1'b0;
    tick(2);
    mon_reset();
    chk_pulses("post_rst");
    snd_rd("post_stat", 2'd1, 8'h04);
    exp_w.push_back(PW);
    main_write(8'h78);
    chk_pulses("post_wr");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtbubl_snd_comm.md
Name: jtbubl_snd_comm

Overview:
- Sound-CPU end of the main-to-sound command channel.
- Receives the main CPU latch write strobe and data, holds the command for the sound Z80, and raises a gated, edge-shaped NMI.
- Returns a reply byte plus status flags to the main side.
- Sits in the sound subsystem between the main-side latch strobe and the sound Z80 address decoder (B000-B003 region).

Parameters:
- NMI_W, 4, NMI low-pulse width in cen3 ticks (1-15).
- NMI_EN_RST, 1, reset value of the NMI enable bit.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk24  in  1  system clock
- cen3  in  1  sound CPU clock enable
- main_wr  in  1  level strobe, high while main writes the sound latch
- main_dout  in  8  main CPU write data
- main_rd  in  1  level strobe, high while main reads the reply
- main_reply  out  8  reply byte to main
- reply_full  out  1  reply written and not yet read by main
- snd_cs  in  1  sound-side comm select, already qualified by mreq
- snd_addr  in  2  register select
- snd_rdn  in  1  sound read, active-low
- snd_wrn  in  1  sound write, active-low
- snd_dout  in  8  sound CPU write data
- snd_din  out  8  read data to the sound CPU mux
- snd_nmi_n  out  1  NMI to sound Z80, active-low

Behaviour:
- Reset state: cmd latch=0, cmd_full=0, overrun=0, main_reply=0, reply_full=0, nmi_en=NMI_EN_RST, snd_nmi_n=1, NMI counter=0. Edge-detector history regs reset to 0.
- All strobes are edge-detected on clk24 (rising edge of main_wr, main_rd, and snd_cs&!snd_rdn / snd_cs&!snd_wrn). Each access acts exactly once, however long the strobe is held.
- Main write edge:
  - latch<=main_dout, cmd_full<=1.
  - If cmd_full was already 1, overrun<=1 (sticky).
- Sound register map:
  - Addr 0 read: snd_din=latch. The read edge clears cmd_full.
  - Addr 0 write: main_reply<=snd_dout, reply_full<=1.
  - Addr 1 read: snd_din={5'b0, nmi_en, overrun, cmd_full}. The read edge clears overrun.
  - Addr 1 write: nmi_en<=snd_dout[0].
  - Addr 2 write: cmd_full<=0 and overrun<=0 (flush).
  - Addr 2 and addr 3 reads return 8'hFF.
  - Addr 3 writes are ignored.
  - snd_din is combinational and equals 8'hFF when snd_cs=0.
- Main read edge clears reply_full. main_reply holds its value.
- Simultaneous-event priority:
  - Main write edge and sound latch-read/flush edge in the same clk24: the write wins; cmd_full stays 1 and no overrun is set.
  - Sound reply write and main read edge in the same clk24: the set wins; reply_full=1.
- NMI FSM (states IDLE, PULSE, GAP), advanced on cen3:
  - Trigger = (main write edge while nmi_en=1) OR (nmi_en 0->1 while cmd_full=1). A trigger is latched in a pending bit on clk24.
  - IDLE + pending: go to PULSE, snd_nmi_n<=0, cnt<=NMI_W-1, clear pending.
  - PULSE: decrement cnt. At cnt==0, go to GAP with snd_nmi_n<=1.
  - GAP: lasts one cen3 tick so the Z80 sees a clean falling edge, then return to IDLE.
  - A trigger during PULSE or GAP stays pending, giving exactly one extra pulse afterwards. Triggers are never merged into an extended low level.
  - nmi_en 1->0 during PULSE does not truncate the pulse, but it clears pending.
- Latency: main write edge to snd_nmi_n low is at most 2 cen3 ticks when IDLE.
- Reset mid-pulse: snd_nmi_n returns to 1 immediately (asynchronous) and all flags clear.

Test Plan:
- Reset, then main writes 8'h5A: snd_nmi_n low for exactly 4 cen3 ticks; addr1 read = 8'h05; addr0 read = 8'h5A; then addr1 read = 8'h04.
- Two main writes, 8'h11 then 8'h22, with no sound read: addr0 read = 8'h22; addr1 read shows overrun=1 and cmd_full=1; a second addr1 read (after latch read) shows overrun=0 and cmd_full=0; exactly two NMI pulses separated by a high gap.
- Sound writes addr1=0, main writes 8'h33: no NMI. Sound then writes addr1=1: one NMI pulse; latch reads 8'h33.
- Sound writes addr0=8'hC7: reply_full=1, main_reply=8'hC7. main_rd held 10 clk24: reply_full clears once; main_reply stays 8'hC7.
- Main write edge in the same clk24 as a sound addr0 read edge: cmd_full remains 1 and the new byte is readable.
- Assert rst during PULSE: snd_nmi_n=1 at once. After release, no NMI occurs until the next main write.
